keypad_scanner: RTL

Parametrised matrix-keypad scanner replacing the fixed 4x4 decoder. It drives active-low row strobes over a ROWS x COLS matrix and synchronises the active-low column returns. It debounces over whole scan frames, rejects multi-key (ghosting) frames, and delivers one press event per key as a raw index on a valid/ready handshake to the CPU-side input logic.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} scan_state_t;

   localparam int unsigned LEGEND_W = 8;

   // ASCII legend of a standard 4x4 keypad, indexed row*4+col.
   function automatic logic [LEGEND_W-1:0] legend4x4(input logic [3:0] code);
      logic [LEGEND_W-1:0] ch;
      case (code)
         4'd0:    ch = "1";
         4'd1:    ch = "2";
         4'd2:    ch = "3";
         4'd3:    ch = "A";
         4'd4:    ch = "4";
         4'd5:    ch = "5";
         4'd6:    ch = "6";
         4'd7:    ch = "B";
         4'd8:    ch = "7";
         4'd9:    ch = "8";
         4'd10:   ch = "9";
         4'd11:   ch = "C";
         4'd12:   ch = "*";
         4'd13:   ch = "0";
         4'd14:   ch = "#";
         default: ch = "D";
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for active-low inputs; resets to the idle (all ones) level.
module keypad_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobing keypad scanner with frame-level debounce, ghost rejection and a
// single-entry valid/ready event output.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned ROWS     = 4,
   parameter int unsigned COLS     = 4,
   parameter int unsigned SCAN_DIV = 16,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic [COLS-1:0]                columns,
   output logic [ROWS-1:0]                rows,
   output logic [$clog2(ROWS*COLS)-1:0]   key_code,
   output logic                           key_valid,
   input  logic                           key_ready,
   output logic                           key_held,
   output logic                           overflow
);

   localparam int unsigned KW = $clog2(ROWS*COLS);
   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);

   logic [COLS-1:0]            col_s;
   logic [RW-1:0]              r, r_nxt;
   logic [DW-1:0]              d, d_nxt;
   logic                       row_done, frame_end;
   logic [ROWS-1:0][COLS-1:0]  bitmap, frame;
   logic [1:0]                 ones;
   logic [KW-1:0]              hit;
   logic                       none, single;
   scan_state_t                state, state_nxt;
   logic [KW-1:0]              cand, cand_nxt, emit_code;
   logic [CW-1:0]              cnt, cnt_nxt;
   logic                       emit;

   keypad_sync #(.WIDTH(COLS)) u_sync (
      .clk  (clk),
      .nrst (nrst),
      .d    (columns),
      .q    (col_s)
   );

   // Dwell and row counters.
   always_comb begin
      row_done = (d == DW'(SCAN_DIV - 1));
      d_nxt    = d + DW'(1);
      r_nxt    = r;
      if (row_done) begin
         d_nxt = '0;
         r_nxt = (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
      end
      frame_end = row_done && (r == RW'(ROWS - 1));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r      <= '0;
         d      <= '0;
         rows   <= '1;
         bitmap <= '0;
      end else begin
         r    <= r_nxt;
         d    <= d_nxt;
         rows <= ~(ROWS'(1) << r_nxt);
         if (row_done) bitmap[r] <= ~col_s;
      end
   end

   // Classify the frame including the row being captured on this edge.
   always_comb begin
      frame    = bitmap;
      frame[r] = ~col_s;
      ones     = 2'd0;
      hit      = '0;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            if (frame[i][j]) begin
               if (ones != 2'd2) ones = ones + 2'd1;
               hit = KW'(i * COLS + j);
            end
         end
      end
      none   = (ones == 2'd0);
      single = (ones == 2'd1);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cand  <= cand_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Debounce decisions are only taken once per frame.
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      emit      = 1'b0;
      emit_code = cand;
      if (frame_end) begin
         case (state)
            IDLE: begin
               if (single) begin
                  cand_nxt  = hit;
                  emit_code = hit;
                  if (DEBOUNCE == 1) begin
                     state_nxt = HELD;
                     emit      = 1'b1;
                  end else begin
                     state_nxt = CONFIRM;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
            CONFIRM: begin
               if (single && (hit == cand)) begin
                  if (cnt == CW'(DEBOUNCE - 1)) begin
                     state_nxt = HELD;
                     emit      = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end else if (single) begin
                  cand_nxt = hit;
                  cnt_nxt  = CW'(1);
               end else begin
                  state_nxt = IDLE;
               end
            end
            HELD: begin
               if (none) begin
                  if (DEBOUNCE == 1) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = RELEASE;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
            RELEASE: begin
               if (none) begin
                  if (cnt == CW'(DEBOUNCE - 1)) state_nxt = IDLE;
                  else                          cnt_nxt   = cnt + CW'(1);
               end else begin
                  state_nxt = HELD;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Event register: a concurrent transfer frees the slot for a new emit.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         key_held <= (state_nxt == HELD) || (state_nxt == RELEASE);
         if (emit && (!key_valid || key_ready)) begin
            key_code  <= emit_code;
            key_valid <= 1'b1;
         end else begin
            if (emit)                   overflow  <= 1'b1;
            if (key_valid && key_ready) key_valid <= 1'b0;
         end
      end
   end

endmodule
